// File: rtl/time_bcd_serializer_pkg.sv
// Shared types, constants and the 12 h hour-mapping helper for the BCD time serializer.
package time_conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PREP  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } conv_state_t;

    localparam int unsigned DIGIT_W       = 4;
    localparam int unsigned HOURS_PER_DAY = 24;
    localparam int unsigned HOURS_HALF    = HOURS_PER_DAY / 2;
    localparam int unsigned HR_W          = 5;

    typedef struct packed {
        logic [HR_W-1:0] hour;
        logic            pm;
    } hr_map_t;

    // Map a legal 0..23 hour onto the 1..12 dial; 0 shows as 12 AM, 12 as 12 PM.
    function automatic hr_map_t hr_map_12h(input logic [HR_W-1:0] value);
        hr_map_t r;
        r.pm = (value >= HR_W'(HOURS_HALF));
        if (value == '0) begin
            r.hour = HR_W'(HOURS_HALF);
        end else if (value > HR_W'(HOURS_HALF)) begin
            r.hour = value - HR_W'(HOURS_HALF);
        end else begin
            r.hour = value;
        end
        return r;
    endfunction

endpackage

// File: rtl/time_bcd_serializer_if.sv
// Handshake and payload bundle between time counters, the serializer and the digit drivers.
interface time_bcd_serializer_if #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned BIN_W  = 6,
    parameter int unsigned DIGITS = 2
);
    import time_conv_pkg::*;

    localparam int unsigned DIN_W = NUM_CH * BIN_W;
    localparam int unsigned BCD_W = NUM_CH * DIGITS * DIGIT_W;

    logic              in_valid;
    logic              in_ready;
    logic              mode_24h;
    logic [DIN_W-1:0]  din;
    logic              out_valid;
    logic              out_ready;
    logic [BCD_W-1:0]  bcd_out;
    logic [NUM_CH-1:0] ovf;
    logic              pm;

    modport master (
        output in_valid, mode_24h, din, out_ready,
        input  in_ready, out_valid, bcd_out, ovf, pm
    );

    modport slave (
        input  in_valid, mode_24h, din, out_ready,
        output in_ready, out_valid, bcd_out, ovf, pm
    );

endinterface

// File: rtl/time_bcd_serializer_add3.sv
// One double-dabble step: add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by one.
module bcd_add3_shift
    import time_conv_pkg::*;
#(
    parameter int unsigned DIGITS = 2,
    parameter int unsigned BIN_W  = 6
) (
    input  logic [DIGITS*DIGIT_W+BIN_W-1:0] din,
    output logic [DIGITS*DIGIT_W+BIN_W-1:0] dout
);

    localparam int unsigned SH_W = DIGITS * DIGIT_W + BIN_W;

    logic [SH_W-1:0] adj;

    // Per-nibble correction followed by the single-bit shift.
    always_comb begin
        adj = din;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (din[BIN_W + d*DIGIT_W +: DIGIT_W] >= DIGIT_W'(5)) begin
                adj[BIN_W + d*DIGIT_W +: DIGIT_W] = din[BIN_W + d*DIGIT_W +: DIGIT_W] + DIGIT_W'(3);
            end
        end
        dout = adj << 1;
    end

endmodule

// File: rtl/time_bcd_serializer.sv
// Sequential binary-to-BCD converter for a set of time channels with 12/24 h hour mapping.
module time_bcd_serializer
    import time_conv_pkg::*;
#(
    parameter int unsigned NUM_CH  = 3,
    parameter int unsigned BIN_W   = 6,
    parameter int unsigned DIGITS  = 2,
    parameter int unsigned MAX_VAL = 59
) (
    input  logic                  clk,
    input  logic                  rst_n,
    time_bcd_serializer_if.slave  bus
);

    localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W    = $clog2(BIN_W + 1);
    localparam int unsigned CH_BCD_W = DIGITS * DIGIT_W;
    localparam int unsigned SH_W     = CH_BCD_W + BIN_W;
    localparam int unsigned BCD_W    = NUM_CH * CH_BCD_W;
    localparam int unsigned DIN_W    = NUM_CH * BIN_W;
    localparam logic [CH_BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

    conv_state_t         state_q, state_nxt;
    logic [CH_W-1:0]     ch_idx_q;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [DIN_W-1:0]    din_q;
    logic                mode_q;
    logic [SH_W-1:0]     sh_q, sh_nxt;
    logic                cur_ovf_q;
    logic [BCD_W-1:0]    stage_bcd_q, stage_nxt;
    logic [NUM_CH-1:0]   stage_ovf_q;
    logic                stage_pm_q;
    logic [BCD_W-1:0]    bcd_out_q;
    logic [NUM_CH-1:0]   ovf_q;
    logic                pm_q;
    logic                out_valid_q;

    logic                in_ready_c;
    logic                accept_c;
    logic                shift_done_c;
    logic                last_ch_c;
    logic [BIN_W-1:0]    cur_bin;
    logic [BIN_W-1:0]    prep_val;
    logic                prep_ovf;
    logic                prep_pm;
    hr_map_t             hm;

    // Shared double-dabble step, reused for every channel.
    bcd_add3_shift #(
        .DIGITS (DIGITS),
        .BIN_W  (BIN_W)
    ) u_step (
        .din  (sh_q),
        .dout (sh_nxt)
    );

    assign last_ch_c = (ch_idx_q == CH_W'(NUM_CH - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:  if (accept_c) state_nxt = PREP;
            PREP:  state_nxt = SHIFT;
            SHIFT: if (shift_done_c) state_nxt = last_ch_c ? DONE : PREP;
            DONE:  if (bus.out_ready) state_nxt = accept_c ? PREP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM control outputs.
    always_comb begin
        in_ready_c   = 1'b0;
        shift_done_c = 1'b0;
        case (state_q)
            IDLE:  in_ready_c = 1'b1;
            DONE:  in_ready_c = bus.out_ready;
            SHIFT: shift_done_c = (bit_cnt_q == CNT_W'(1));
            default: ;
        endcase
        accept_c = bus.in_valid & in_ready_c;
    end

    // Range check and hour mapping of the channel about to be converted.
    always_comb begin
        cur_bin = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (ch_idx_q == CH_W'(c)) cur_bin = din_q[c*BIN_W +: BIN_W];
        end
        prep_val = cur_bin;
        prep_pm  = 1'b0;
        hm       = '0;
        if (ch_idx_q == '0) begin
            prep_ovf = (32'(cur_bin) >= HOURS_PER_DAY);
            prep_pm  = (32'(cur_bin) >= HOURS_HALF);
            if (!prep_ovf && !mode_q) begin
                hm       = hr_map_12h(HR_W'(cur_bin));
                prep_val = BIN_W'(hm.hour);
                prep_pm  = hm.pm;
            end
        end else begin
            prep_ovf = (32'(cur_bin) > MAX_VAL);
        end
    end

    // Staging image with the finished channel's digits merged in.
    always_comb begin
        stage_nxt = stage_bcd_q;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (ch_idx_q == CH_W'(c)) begin
                stage_nxt[c*CH_BCD_W +: CH_BCD_W] = cur_ovf_q ? ALL_NINES : sh_nxt[SH_W-1 -: CH_BCD_W];
            end
        end
    end

    // Datapath: capture, per-channel load/shift, staging and presented results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_idx_q    <= '0;
            bit_cnt_q   <= '0;
            din_q       <= '0;
            mode_q      <= 1'b0;
            sh_q        <= '0;
            cur_ovf_q   <= 1'b0;
            stage_bcd_q <= '0;
            stage_ovf_q <= '0;
            stage_pm_q  <= 1'b0;
            bcd_out_q   <= '0;
            ovf_q       <= '0;
            pm_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= (state_nxt == DONE);
            if (accept_c) begin
                din_q    <= bus.din;
                mode_q   <= bus.mode_24h;
                ch_idx_q <= '0;
            end
            if (state_q == PREP) begin
                sh_q      <= SH_W'(prep_val);
                bit_cnt_q <= CNT_W'(BIN_W);
                cur_ovf_q <= prep_ovf;
                for (int c = 0; c < int'(NUM_CH); c++) begin
                    if (ch_idx_q == CH_W'(c)) stage_ovf_q[c] <= prep_ovf;
                end
                if (ch_idx_q == '0) stage_pm_q <= prep_pm;
            end
            if (state_q == SHIFT) begin
                sh_q      <= sh_nxt;
                bit_cnt_q <= bit_cnt_q - CNT_W'(1);
                if (shift_done_c) begin
                    stage_bcd_q <= stage_nxt;
                    if (last_ch_c) begin
                        bcd_out_q <= stage_nxt;
                        ovf_q     <= stage_ovf_q;
                        pm_q      <= stage_pm_q;
                    end else begin
                        ch_idx_q <= ch_idx_q + CH_W'(1);
                    end
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.bcd_out   = bcd_out_q;
    assign bus.ovf       = ovf_q;
    assign bus.pm        = pm_q;

endmodule
